// File: rtl/machine_timer_pkg.sv
// machine_timer_pkg: register offsets, bus access size encoding and the
// byte-lane helpers shared by the machine timer.
package machine_timer_pkg;

   // Register offsets inside the 32-byte window
   localparam logic [4:0] OFF_MSIP        = 5'h00;
   localparam logic [4:0] OFF_CONTROL     = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFF_MTIME_LO    = 5'h10;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h14;
   localparam logic [4:0] OFF_PRESCALE    = 5'h18;
   localparam logic [4:0] OFF_RESERVED    = 5'h1C;

   // CPU access size; encoding 3 is reserved and behaves like a word
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } data_size_e;

   // Byte-enable mask for an access; a misaligned halfword enables nothing
   function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                              input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << offset;
         SIZE_HALF: begin
            if (offset == 2'd0) begin
               mask = 4'b0011;
            end else if (offset == 2'd2) begin
               mask = 4'b1100;
            end else begin
               mask = 4'b0000;
            end
         end
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Move right-aligned write data onto its byte lanes; words are not shifted
   function automatic logic [31:0] align_write(input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset);
      logic [31:0] aligned;
      case (size)
         SIZE_BYTE: aligned = data << {offset, 3'b000};
         SIZE_HALF: aligned = data << {offset, 3'b000};
         default:   aligned = data;
      endcase
      return aligned;
   endfunction

   // Replace only the enabled byte lanes of a word
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the count-enable down to one tick every
// (divisor + 1) enabled cycles. Used only when MACHINE_TIMER_PRESCALER_EN
// is defined.
module timer_prescaler (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] divisor,
   input  logic        clear,
   output logic        tick
);

   logic [15:0] r_count;

   // Tick is issued in the same cycle the counter reaches the divisor
   assign tick = enable && (r_count == divisor);

   // Prescale counter: cleared by reconfiguration, wraps on tick, holds when disabled
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= 16'd0;
      end else if (clear) begin
         r_count <= 16'd0;
      end else if (tick) begin
         r_count <= 16'd0;
      end else if (enable) begin
         r_count <= r_count + 16'd1;
      end else begin
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V mtime/mtimecmp/msip block on the CPU
// data bus. Optional prescaler is built when MACHINE_TIMER_PRESCALER_EN is
// defined; otherwise mtime advances every cycle that control[0] is set.
module machine_timer
   import machine_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_bus,
   input  logic [31:0] data_bus_in,
   input  logic [1:0]  data_size,
   input  logic        write,
   input  logic        read,
   output logic [31:0] data_bus_out,
   output logic        selected,
   output logic        timer_interrupt,
   output logic        software_interrupt
);

   logic        r_msip;
   logic        r_control;
   logic [63:0] r_mtimecmp;
   logic [63:0] r_mtime;
   logic        r_timer_interrupt;

   logic        w_selected;
   logic [2:0]  w_index;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_wr;
   logic        w_wr_msip;
   logic        w_wr_control;
   logic        w_wr_cmp_lo;
   logic        w_wr_cmp_hi;
   logic        w_wr_mtime_lo;
   logic        w_wr_mtime_hi;
   logic        w_tick;
   logic [63:0] w_mtime_next;
   logic [31:0] w_prescale_rd;
   logic [31:0] w_rdata;

   // Address decode and write lane selection
   assign w_selected = (address_bus[31:5] == BASE_ADDRESS[31:5]);
   assign w_index    = address_bus[4:2];
   assign w_be       = byte_enable(data_size, address_bus[1:0]);
   assign w_wdata    = align_write(data_bus_in, data_size, address_bus[1:0]);

   // An access with no enabled lanes (misaligned halfword) is not a write at all
   assign w_wr          = w_selected && write && (w_be != 4'b0000);
   assign w_wr_msip     = w_wr && (w_index == OFF_MSIP[4:2]);
   assign w_wr_control  = w_wr && (w_index == OFF_CONTROL[4:2]);
   assign w_wr_cmp_lo   = w_wr && (w_index == OFF_MTIMECMP_LO[4:2]);
   assign w_wr_cmp_hi   = w_wr && (w_index == OFF_MTIMECMP_HI[4:2]);
   assign w_wr_mtime_lo = w_wr && (w_index == OFF_MTIME_LO[4:2]);
   assign w_wr_mtime_hi = w_wr && (w_index == OFF_MTIME_HI[4:2]);

`ifdef MACHINE_TIMER_PRESCALER_EN
   logic        w_wr_prescale;
   logic [15:0] r_prescale;

   assign w_wr_prescale = w_wr && (w_index == OFF_PRESCALE[4:2]);
   assign w_prescale_rd = {16'h0000, r_prescale};

   // Prescale divisor register, byte-lane writable on its low two lanes
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prescale <= 16'd0;
      end else if (w_wr_prescale) begin
         if (w_be[0]) begin
            r_prescale[7:0] <= w_wdata[7:0];
         end
         if (w_be[1]) begin
            r_prescale[15:8] <= w_wdata[15:8];
         end
      end
   end

   timer_prescaler u_prescaler (
      .clock   (clock),
      .reset   (reset),
      .enable  (r_control),
      .divisor (r_prescale),
      .clear   (w_wr_control || w_wr_prescale),
      .tick    (w_tick)
   );
`else
   assign w_prescale_rd = 32'h0000_0000;
   assign w_tick        = r_control;
`endif

   // msip and count-enable bits live in lane 0 of their words
   always_ff @(posedge clock) begin
      if (reset) begin
         r_msip    <= 1'b0;
         r_control <= 1'b1;
      end else begin
         if (w_wr_msip && w_be[0]) begin
            r_msip <= w_wdata[0];
         end
         if (w_wr_control && w_be[0]) begin
            r_control <= w_wdata[0];
         end
      end
   end

   // mtimecmp halves, byte-lane writable
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (w_wr_cmp_lo) begin
         r_mtimecmp[31:0] <= merge_lanes(r_mtimecmp[31:0], w_wdata, w_be);
      end else if (w_wr_cmp_hi) begin
         r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], w_wdata, w_be);
      end
   end

   // Next mtime: a software write wins over the tick and suppresses the increment
   always_comb begin
      w_mtime_next = r_mtime;
      if (w_wr_mtime_lo) begin
         w_mtime_next[31:0] = merge_lanes(r_mtime[31:0], w_wdata, w_be);
      end else if (w_wr_mtime_hi) begin
         w_mtime_next[63:32] = merge_lanes(r_mtime[63:32], w_wdata, w_be);
      end else if (w_tick) begin
         w_mtime_next = r_mtime + 64'd1;
      end else begin
         w_mtime_next = r_mtime;
      end
   end

   // mtime counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mtime <= 64'd0;
      end else begin
         r_mtime <= w_mtime_next;
      end
   end

   // Timer interrupt level, one cycle behind the compared state
   always_ff @(posedge clock) begin
      if (reset) begin
         r_timer_interrupt <= 1'b0;
      end else begin
         r_timer_interrupt <= (r_mtime >= r_mtimecmp);
      end
   end

   // Read mux: full aligned word, pre-write contents
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (w_index)
         OFF_MSIP[4:2]:        w_rdata = {31'd0, r_msip};
         OFF_CONTROL[4:2]:     w_rdata = {31'd0, r_control};
         OFF_MTIMECMP_LO[4:2]: w_rdata = r_mtimecmp[31:0];
         OFF_MTIMECMP_HI[4:2]: w_rdata = r_mtimecmp[63:32];
         OFF_MTIME_LO[4:2]:    w_rdata = r_mtime[31:0];
         OFF_MTIME_HI[4:2]:    w_rdata = r_mtime[63:32];
         OFF_PRESCALE[4:2]:    w_rdata = w_prescale_rd;
         OFF_RESERVED[4:2]:    w_rdata = 32'h0000_0000;
         default:              w_rdata = 32'h0000_0000;
      endcase
   end

   assign data_bus_out       = (w_selected && read) ? w_rdata : 32'h0000_0000;
   assign selected           = w_selected;
   assign timer_interrupt    = r_timer_interrupt;
   assign software_interrupt = r_msip;

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed scenarios plus a randomized run, checked against
// a behavioural model of the timer register file kept in the bench.
module tb_machine_timer;

   localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef MACHINE_TIMER_PRESCALER_EN
   localparam bit PRESC_EN = 1'b1;
`else
   localparam bit PRESC_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] address_bus;
   logic [31:0] data_bus_in;
   logic [1:0]  data_size;
   logic        write;
   logic        read;
   logic [31:0] data_bus_out;
   logic        selected;
   logic        timer_interrupt;
   logic        software_interrupt;

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model state
   logic [63:0] m_mtime, m_cmp;
   logic        m_msip, m_ctrl, m_tint;
   logic [15:0] m_pre, m_cnt;

   machine_timer #(.BASE_ADDRESS(BASE)) dut (
      .clock              (clock),
      .reset              (reset),
      .address_bus        (address_bus),
      .data_bus_in        (data_bus_in),
      .data_size          (data_size),
      .write              (write),
      .read               (read),
      .data_bus_out       (data_bus_out),
      .selected           (selected),
      .timer_interrupt    (timer_interrupt),
      .software_interrupt (software_interrupt)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit in_window(input logic [31:0] a);
      return (a & 32'hFFFF_FFE0) == BASE;
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  = 1'b0;
      m_ctrl  = 1'b1;
      m_pre   = 16'd0;
      m_cnt   = 16'd0;
      m_tint  = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
      if (!r || !in_window(a)) return 32'h0;
      case (a[4:2])
         3'd0:    return {31'd0, m_msip};
         3'd1:    return {31'd0, m_ctrl};
         3'd2:    return m_cmp[31:0];
         3'd3:    return m_cmp[63:32];
         3'd4:    return m_mtime[31:0];
         3'd5:    return m_mtime[63:32];
         3'd6:    return PRESC_EN ? {16'd0, m_pre} : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge of the register file: the list of written bytes is
   // built first, then applied to the named registers.
   task automatic model_step(input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] s);
      int          lanes[$];
      logic [7:0]  vals[$];
      logic [63:0] new_mt;
      bit          tick, written, clr, ctrl_old;
      ctrl_old = m_ctrl;
      tick     = PRESC_EN ? (m_ctrl && (m_cnt == m_pre)) : m_ctrl;
      m_tint   = (m_mtime >= m_cmp);
      new_mt   = m_mtime;
      written  = 1'b0;
      clr      = 1'b0;
      if (w && in_window(a)) begin
         case (s)
            2'd0: begin
               lanes.push_back(int'(a[1:0])); vals.push_back(d[7:0]);
            end
            2'd1: begin
               if (a[0] == 1'b0) begin
                  lanes.push_back(int'(a[1:0]));     vals.push_back(d[7:0]);
                  lanes.push_back(int'(a[1:0]) + 1); vals.push_back(d[15:8]);
               end
            end
            default: begin
               for (int k = 0; k < 4; k++) begin
                  lanes.push_back(k); vals.push_back(d[8*k +: 8]);
               end
            end
         endcase
         for (int i = 0; i < lanes.size(); i++) begin
            case (a[4:2])
               3'd0: if (lanes[i] == 0) m_msip = vals[i][0];
               3'd1: begin clr = 1'b1; if (lanes[i] == 0) m_ctrl = vals[i][0]; end
               3'd2: m_cmp[8*lanes[i] +: 8] = vals[i];
               3'd3: m_cmp[32 + 8*lanes[i] +: 8] = vals[i];
               3'd4: begin new_mt[8*lanes[i] +: 8] = vals[i]; written = 1'b1; end
               3'd5: begin new_mt[32 + 8*lanes[i] +: 8] = vals[i]; written = 1'b1; end
               3'd6: begin
                  clr = 1'b1;
                  if (PRESC_EN && lanes[i] < 2) m_pre[8*lanes[i] +: 8] = vals[i];
               end
               default: ;
            endcase
         end
      end
      if (PRESC_EN) begin
         if (clr || tick) m_cnt = 16'd0;
         else if (ctrl_old) m_cnt = m_cnt + 16'd1;
      end
      if (written) m_mtime = new_mt;
      else if (tick) m_mtime = m_mtime + 64'd1;
   endtask

   // Drive one bus cycle (called just after a rising edge), capture the
   // combinational read data and the model's expectation for it.
   task automatic do_cycle(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s,
                           output logic [31:0] rd, output logic [31:0] exp_rd);
      write = w; read = r; address_bus = a; data_bus_in = d; data_size = s;
      #2;
      rd     = data_bus_out;
      exp_rd = model_read(r, a);
      @(posedge clock);
      model_step(w, a, d, s);
      #1;
      write = 1'b0; read = 1'b0;
   endtask

   task automatic idle(input int n);
      logic [31:0] rd, ex;
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, BASE, 32'h0, 2'd2, rd, ex);
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [1:0] s);
      logic [31:0] rd, ex;
      do_cycle(1'b1, 1'b0, BASE + {27'd0, off}, d, s, rd, ex);
   endtask

   task automatic rd_reg(input logic [4:0] off, output logic [31:0] rd, output logic [31:0] ex);
      do_cycle(1'b0, 1'b1, BASE + {27'd0, off}, 32'h0, 2'd2, rd, ex);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; write = 1'b1; read = 1'b1; data_size = 2'd2;
      address_bus = BASE + 32'h10; data_bus_in = 32'h0000_1234;
      @(posedge clock); #1;
      @(posedge clock); #1;
      model_reset();
      write = 1'b0;
      tests_run++;
      if (timer_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL reset_tint: got %b expected 0", timer_interrupt);
      end
      tests_run++;
      if (software_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL reset_swi: got %b expected 0", software_interrupt);
      end
      #1;
      tests_run++;
      if (data_bus_out !== 32'h0) begin
         tests_failed++; $display("FAIL reset_write_ignored: mtime lo got %h expected 0", data_bus_out);
      end
      address_bus = BASE + 32'h08; #1;
      tests_run++;
      if (data_bus_out !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL reset_cmp_lo: got %h expected ffffffff", data_bus_out);
      end
      address_bus = BASE + 32'h04; #1;
      tests_run++;
      if (data_bus_out !== 32'h1 || selected !== 1'b1) begin
         tests_failed++; $display("FAIL reset_control: got %h sel %b expected 1 sel 1", data_bus_out, selected);
      end
      read = 1'b0; #1;
      tests_run++;
      if (data_bus_out !== 32'h0) begin
         tests_failed++; $display("FAIL read_low_zero: got %h expected 0", data_bus_out);
      end
      reset = 1'b0;
   endtask

   task automatic test_idle_count();
      logic [31:0] rd, ex;
      idle(10);
      rd_reg(5'h10, rd, ex);
      tests_run++;
      if (rd !== 32'd10) begin
         tests_failed++; $display("FAIL idle_mtime: got %0d expected 10", rd);
      end
      rd_reg(5'h08, rd, ex);
      tests_run++;
      if (rd !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL idle_cmp_lo: got %h expected ffffffff", rd);
      end
      rd_reg(5'h0C, rd, ex);
      tests_run++;
      if (rd !== 32'hFFFF_FFFF) begin
         tests_failed++; $display("FAIL idle_cmp_hi: got %h expected ffffffff", rd);
      end
      tests_run++;
      if (timer_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL idle_tint: got %b expected 0", timer_interrupt);
      end
   endtask

   task automatic test_carry();
      logic [31:0] rd, ex;
      wr(5'h10, 32'hFFFF_FFFE, 2'd2);
      wr(5'h14, 32'h0000_0000, 2'd2);
      rd_reg(5'h10, rd, ex);
      tests_run++;
      if (rd !== 32'hFFFF_FFFE) begin
         tests_failed++; $display("FAIL write_no_inc: got %h expected fffffffe", rd);
      end
      idle(1);
      rd_reg(5'h10, rd, ex);
      tests_run++;
      if (rd !== 32'h0) begin
         tests_failed++; $display("FAIL carry_lo: got %h expected 0", rd);
      end
      rd_reg(5'h14, rd, ex);
      tests_run++;
      if (rd !== 32'h1) begin
         tests_failed++; $display("FAIL carry_hi: got %h expected 1", rd);
      end
   endtask

   task automatic test_compare();
      int first_high;
      apply_reset();
      wr(5'h0C, 32'h0, 2'd2);
      wr(5'h08, 32'd5, 2'd2);
      first_high = -1;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         tests_run++;
         if (timer_interrupt !== m_tint) begin
            tests_failed++; $display("FAIL cmp_track[%0d]: got %b expected %b", i, timer_interrupt, m_tint);
         end
         if (timer_interrupt === 1'b1 && first_high < 0) first_high = i;
      end
      tests_run++;
      if (first_high !== 3 || timer_interrupt !== 1'b1) begin
         tests_failed++; $display("FAIL cmp_rise: first high at %0d level %b expected 3 and 1", first_high, timer_interrupt);
      end
      wr(5'h0C, 32'h1, 2'd2);
      tests_run++;
      if (timer_interrupt !== 1'b1) begin
         tests_failed++; $display("FAIL cmp_lag: got %b expected 1", timer_interrupt);
      end
      idle(1);
      tests_run++;
      if (timer_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL cmp_drop: got %b expected 0", timer_interrupt);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, ex;
      apply_reset();
      wr(5'h0D, 32'h0000_00AB, 2'd0);
      rd_reg(5'h0C, rd, ex);
      tests_run++;
      if (rd !== 32'hFFFF_ABFF) begin
         tests_failed++; $display("FAIL byte_write: got %h expected ffffabff", rd);
      end
      wr(5'h03, 32'h0000_FFFF, 2'd1);
      rd_reg(5'h00, rd, ex);
      tests_run++;
      if (rd !== 32'h0 || software_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL misaligned_msip: got %h swi %b expected 0", rd, software_interrupt);
      end
      wr(5'h0F, 32'h0000_1234, 2'd1);
      rd_reg(5'h0C, rd, ex);
      tests_run++;
      if (rd !== 32'hFFFF_ABFF) begin
         tests_failed++; $display("FAIL misaligned_cmp: got %h expected ffffabff", rd);
      end
      wr(5'h0E, 32'h0000_1234, 2'd1);
      rd_reg(5'h0C, rd, ex);
      tests_run++;
      if (rd !== 32'h1234_ABFF) begin
         tests_failed++; $display("FAIL half_upper: got %h expected 1234abff", rd);
      end
   endtask

   task automatic test_msip();
      logic [31:0] rd, ex;
      do_cycle(1'b1, 1'b1, BASE, 32'h1, 2'd2, rd, ex);
      tests_run++;
      if (rd !== 32'h0 || software_interrupt !== 1'b1) begin
         tests_failed++; $display("FAIL msip_set: read %h swi %b expected 0 and 1", rd, software_interrupt);
      end
      do_cycle(1'b1, 1'b1, BASE, 32'h0, 2'd2, rd, ex);
      tests_run++;
      if (rd !== 32'h1 || software_interrupt !== 1'b0) begin
         tests_failed++; $display("FAIL msip_clear: read %h swi %b expected 1 and 0", rd, software_interrupt);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] rd, ex, a_val, b_val;
      apply_reset();
      wr(5'h18, 32'd3, 2'd2);
      rd_reg(5'h18, rd, ex);
      tests_run++;
      if (rd !== (PRESC_EN ? 32'd3 : 32'd0)) begin
         tests_failed++; $display("FAIL prescale_read: got %h expected %h", rd, PRESC_EN ? 32'd3 : 32'd0);
      end
      rd_reg(5'h10, a_val, ex);
      idle(7);
      rd_reg(5'h10, b_val, ex);
      tests_run++;
      if ((b_val - a_val) !== (PRESC_EN ? 32'd2 : 32'd8) || b_val !== ex) begin
         tests_failed++; $display("FAIL prescale_rate: got delta %0d value %h expected delta %0d value %h",
                                  b_val - a_val, b_val, PRESC_EN ? 2 : 8, ex);
      end
      wr(5'h04, 32'h0, 2'd2);
      idle(3);
      rd_reg(5'h10, a_val, ex);
      rd_reg(5'h10, b_val, ex);
      tests_run++;
      if (a_val !== b_val || b_val !== ex) begin
         tests_failed++; $display("FAIL freeze: got %h then %h expected %h", a_val, b_val, ex);
      end
      wr(5'h04, 32'h1, 2'd2);
   endtask

   task automatic test_random();
      logic [31:0] rd, ex, a, d;
      logic        w, r;
      logic [1:0]  s;
      for (int i = 0; i < 400; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         s = 2'($urandom_range(0, 3));
         d = $urandom;
         if ($urandom_range(0, 7) == 0) a = BASE ^ (32'h1 << $urandom_range(5, 31));
         else a = BASE + 32'($urandom_range(0, 31));
         if (a[4:2] == 3'd1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         if (a[4:2] == 3'd6) d[15:2] = 14'd0;
         do_cycle(w, r, a, d, s, rd, ex);
         tests_run++;
         if (rd !== ex || selected !== in_window(a) || timer_interrupt !== m_tint ||
             software_interrupt !== m_msip) begin
            tests_failed++;
            $display("FAIL random[%0d]: rd %h sel %b tint %b swi %b expected rd %h sel %b tint %b swi %b",
                     i, rd, selected, timer_interrupt, software_interrupt, ex, in_window(a), m_tint, m_msip);
         end
      end
   endtask

   initial begin
      reset = 1'b1; write = 1'b0; read = 1'b0;
      address_bus = BASE; data_bus_in = 32'h0; data_size = 2'd2;
      model_reset();
      test_reset();
      test_idle_count();
      test_carry();
      test_compare();
      test_byte_lanes();
      test_msip();
      test_prescale();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer and software-interrupt source on the CPU's simple data bus. Decodes CPU bus cycles (address, write data, size, read/write strobes) and holds the 64-bit `mtime` counter, 64-bit `mtimecmp` compare register and `msip` bit. Drives the CPU's `timer_interrupt` and `software_interrupt` pads. Its read data is merged into the CPU's `data_bus_in`.

## Interface
- `BASE_ADDRESS`, default 32'h0200_0000: base of the 32-byte register window; bits [4:0] must be zero.
- `clock`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high.
- `address_bus`  in  32: CPU address.
- `data_bus_in`  in  32: CPU write data (CPU `data_bus_out`), right-aligned (byte in [7:0], half in [15:0]).
- `data_size`  in  2: 0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
- `write`  in  1: store strobe.
- `read`  in  1: load strobe.
- `data_bus_out`  out  32: aligned read word; 0 when not selected or `read` low.
- `selected`  out  1: combinational; `address_bus[31:5] == BASE_ADDRESS[31:5]`.
- `timer_interrupt`  out  1: registered `mtime >= mtimecmp` (unsigned 64-bit).
- `software_interrupt`  out  1: equals `msip`.

## Operation
- Register map (offset from base, word-aligned):
  - 0x00 `msip`: bit 0 only; other bits read 0.
  - 0x04 `control`: bit 0 = count enable.
  - 0x08 / 0x0C: `mtimecmp` lo / hi.
  - 0x10 / 0x14: `mtime` lo / hi.
  - 0x18 `prescale`: [15:0].
  - 0x1C: reserved; reads 0, writes ignored.
- Reset values: `mtime` 0, `mtimecmp` all ones, `msip` 0, `control` 1, `prescale` 0, prescale counter 0; all outputs 0.
- Writes (`selected && write`):
  - Byte lanes chosen from `data_size` and `address_bus[1:0]`; write data shifted left by 8×offset.
  - Halfword at offset 1 or 3 is misaligned and ignored entirely; word ignores `address_bus[1:0]`.
  - Unwritten lanes keep their current values.
- Reads (`selected && read`): combinational full aligned word; the CPU extracts lanes. Read and write in the same cycle return the pre-write value.
- Tick: asserted when `control[0]` is set and the prescale counter equals `prescale`; the counter then clears, otherwise it increments. `prescale` = 0 gives a tick every cycle.
- On tick, `mtime` increments as a 64-bit value (lo→hi carry in the same cycle); 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs increment on the same edge: a write to any `mtime` lane takes priority. The whole 64-bit `mtime` becomes the old value with the written lanes merged, with no increment that cycle.
- Writing `prescale` or `control` clears the prescale counter.

## Timing
- Register writes take effect at the edge that samples `write`.
- `timer_interrupt` is computed from post-edge `mtime`/`mtimecmp` and registered, so it lags state by one cycle. It stays high while the condition holds (level, not pulse).
- `software_interrupt` follows `msip` with zero added latency after the write edge.
- Reset asserted mid-operation overrides any coincident write or tick.

## Configuration
- `MACHINE_TIMER_PRESCALER_EN` defined: `prescale` register and prescale counter are built as above.
- Not defined: no prescale storage. Offset 0x18 reads 0 and ignores writes. Tick = `control[0]` every cycle.

## Structure
- Package `machine_timer_pkg`:
  - register offset localparams;
  - `data_size` enum (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - a function returning the 4-bit byte-enable mask from size and offset (zero when misaligned).
- Sub-module `timer_prescaler`: holds the prescale counter, inputs `enable`/`divisor`/`clear`, output `tick`. Only instantiated under `MACHINE_TIMER_PRESCALER_EN`.

## Test plan
- Reset, then idle 10 cycles with `prescale` = 0: `mtime` = 10; `timer_interrupt` = 0; reading 0x08 and 0x0C returns 0xFFFF_FFFF.
- Word-write `mtime` lo = 0xFFFF_FFFE, hi = 0: after 2 ticks lo = 0, hi = 1 (carry); the writing edge itself does not increment.
- Write `mtimecmp` = 5 (hi 0 first, then lo 5) from reset: `timer_interrupt` rises on the cycle after `mtime` reaches 5 and stays high; writing hi = 1 drops it one cycle later.
- Byte-write 0xAB at offset 0x0D: `mtimecmp` hi = 0xFFFF_ABFF. Halfword write at offset 0x03: no register changes.
- Word-write 1 to 0x00: `software_interrupt` = 1; write 0: it clears. Concurrent read at 0x00 returns the old value.
- With `MACHINE_TIMER_PRESCALER_EN`, `prescale` = 3: `mtime` increments every 4th cycle. Clearing `control[0]` freezes it; without the macro, reading 0x18 returns 0 after a write of 3.
